// File: rtl/store_buffer.sv
// Posted-write store buffer between the CPU write port and main memory.
// Stores retire in one cycle, drain in program order, and forward to hitting loads.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_full,
    input  logic [AW-1:0] cpu_raddr,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    logic [AW-3:0] entryAddr [DEPTH];
    logic [DW-1:0] entryData [DEPTH];

    logic doEnq;
    logic doDeq;

    // The low address bits never take part in matching or draining.
    logic unusedBits;
    assign unusedBits = ^{cpu_addr[1:0], cpu_raddr[1:0]};

    // Status is decoded purely from the registered count, so a store
    // refused while full stays refused even if memory acks that cycle.
    assign cpu_full = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign mem_req  = !empty;

    assign doEnq = cpu_we && !cpu_full;
    assign doDeq = mem_req && mem_ack;

    // Memory handshake: the head entry is offered while mem_req=1 and is
    // transferred on a cycle where mem_req=1 and mem_ack=1; until then the
    // address and data stay stable because head only moves on that transfer.
    assign mem_addr  = mem_req ? {entryAddr[head], 2'b00} : '0;
    assign mem_wdata = mem_req ? entryData[head] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (doEnq) begin
                tail <= tail + PW'(1);
            end
            if (doDeq) begin
                head <= head + PW'(1);
            end
            case ({doEnq, doDeq})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doEnq) begin
            entryAddr[tail] <= cpu_addr[AW-1:2];
            entryData[tail] <= cpu_wdata;
        end
    end

    // Walk entries oldest to youngest by offset from head so that a later
    // match overrides an earlier one, independent of where the pointers wrap.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (((PW+1)'(k) < count) &&
                (entryAddr[head + PW'(k)] == cpu_raddr[AW-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = entryData[head + PW'(k)];
            end
        end
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO between the CPU data-bus write port and main memory.
- CPU stores retire in one cycle into the buffer. The buffer drains them in order to memory over a req/ack handshake.
- Loads that hit a pending store are forwarded from the buffer, so the CPU never reads stale memory.
- Sits directly downstream of the CPU core's bus port B, in front of the memory write port.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset asserted)
cpu_we  in  1  store request this cycle
cpu_addr  in  AW  store byte address; bits [1:0] ignored (word-aligned)
cpu_wdata  in  DW  store data
cpu_full  out  1  buffer full; store this cycle is not accepted and the CPU must stall/hold
cpu_raddr  in  AW  load address for forwarding lookup; bits [1:0] ignored
fwd_hit  out  1  combinational: a pending entry matches cpu_raddr
fwd_data  out  DW  combinational: data of youngest matching entry; 0 when fwd_hit=0
mem_req  out  1  head entry valid and presented to memory
mem_addr  out  AW  head entry address, word-aligned (bits [1:0]=0)
mem_wdata  out  DW  head entry data
mem_ack  in  1  memory accepted the head entry this cycle
empty  out  1  no pending entries; used by the CPU for fence/drain

Behaviour:
- State:
  - head and tail pointers, log2(DEPTH) bits each, wrap modulo DEPTH.
  - count, log2(DEPTH)+1 bits.
  - per-entry addr[AW-1:2] and data registers.
- Reset (rst=0, async): head=0, tail=0, count=0. Pending entries are discarded. Outputs: cpu_full=0, mem_req=0, empty=1, fwd_hit=0, fwd_data=0, mem_addr/mem_wdata=0. Entry storage need not be cleared.
- Reset mid-drain: mem_req drops immediately (asynchronously). The memory side must tolerate an abandoned request.
- Flags are decoded from registered count only:
  - cpu_full = (count==DEPTH).
  - empty = (count==0).
  - mem_req = !empty.
- Enqueue: accept when cpu_we=1 and cpu_full=0. Write entry[tail], tail++, count++ at the edge. The entry is visible to mem_req/forwarding from the next cycle.
- Full: cpu_we with cpu_full=1 is ignored, with no state change. This holds even if mem_ack=1 in the same cycle; the freed slot is usable next cycle.
- Dequeue: when mem_req=1 and mem_ack=1, head++ and count-- at the edge. mem_ack while mem_req=0 is ignored.
- Simultaneous accepted enqueue and dequeue: count unchanged, both pointers advance.
- Handshake: mem_addr/mem_wdata are driven from entry[head] and held stable while mem_req=1 and mem_ack=0. Writes reach memory strictly in program order. No coalescing.
- Latency:
  - Store to first mem_req: 1 cycle (enqueue edge, then mem_req high).
  - Back-to-back acks drain 1 entry/cycle.
- Forwarding:
  - Compare cpu_raddr[AW-1:2] against every valid entry, where valid means the slot index lies in [head, head+count) modulo DEPTH.
  - On multiple matches, select the youngest (closest to tail).
  - A store being enqueued in the same cycle is NOT forwarded. The CPU guarantees it does not load a word stored in the same cycle.
  - The entry being acked this cycle is still forwarded this cycle.
- Wrap-around: pointers wrap DEPTH-1 → 0. Age ordering for forwarding uses offset (index-head) mod DEPTH.

Test Plan:
- Reset/idle: rst=0 then 1, no stimulus → empty=1, cpu_full=0, mem_req=0, fwd_hit=0 for 10 cycles.
- Single store: cpu_we with addr 0x0000_0104, data 0xDEAD_BEEF; mem_ack held 0 for 3 cycles, then 1 →
  - mem_req=1 from the next cycle, with mem_addr=0x104 and mem_wdata=0xDEADBEEF stable through the stall.
  - empty=1 the cycle after the ack.
- Fill and full: 5 stores to 0x0,0x4,0x8,0xC,0x10 on consecutive cycles, mem_ack=0 →
  - cpu_full=1 after the 4th store; the 5th store is dropped.
  - With mem_ack=1 the drain order is 0x0,0x4,0x8,0xC, one per cycle.
- Forwarding priority: stores 0x20←1, 0x24←2, 0x20←3, mem_ack=0; cpu_raddr=0x22 → fwd_hit=1, fwd_data=3. cpu_raddr=0x28 → fwd_hit=0, fwd_data=0.
- Wrap and concurrency: DEPTH=4, continuous mem_ack=1 with a store every cycle for 10 cycles (data=i) → count never exceeds 1, memory sees data 0..9 in order, pointers wrap twice.
- Reset mid-operation: 3 pending entries, assert rst=0 for 1 cycle → mem_req falls immediately, empty=1, and no further memory writes occur.
